// File: rtl/booth_datapath.sv
// Radix-2 Booth multiplier datapath: M, A (sign-extended), Q, Q-1 and iteration counter.
// Optional macro BOOTH_DP_REG_OUT_EN registers outbus (1-cycle latency); default is combinational.
module booth_datapath #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       c,
  input  logic [WIDTH-1:0] inbus,
  output logic [WIDTH-1:0] outbus,
  output logic             q0,
  output logic             qm,
  output logic             count
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic                    ld_m;
  logic                    ld_q;
  logic                    addsub_en;
  logic                    sub_sel;
  logic                    shr_en;
  logic                    cnt_inc;
  logic                    out_a;
  logic                    out_q;

  logic signed [WIDTH-1:0] m_reg;
  logic signed [WIDTH:0]   a_reg;
  logic        [WIDTH-1:0] q_reg;
  logic                    qm_reg;
  logic        [CNT_W-1:0] cnt_reg;

  logic signed [WIDTH:0]   a_arith_p0;
  logic signed [WIDTH:0]   a_shift_p0;
  logic        [WIDTH-1:0] q_shift_p0;
  logic                    qm_shift_p0;

  logic signed [WIDTH:0]   a_nxt;
  logic        [WIDTH-1:0] q_nxt;
  logic                    qm_nxt;
  logic        [CNT_W-1:0] cnt_nxt;
  logic        [WIDTH-1:0] out_sel_p0;

  // A +/- sext(M), wrapping modulo 2^(WIDTH+1); the extra A bit absorbs -2^(WIDTH-1) operands.
  function automatic logic signed [WIDTH:0] add_sub(input logic signed [WIDTH:0]   a,
                                                    input logic signed [WIDTH-1:0] m,
                                                    input logic                    sub);
    logic signed [WIDTH:0] m_ext;
    m_ext = {m[WIDTH-1], m};
    return sub ? (a - m_ext) : (a + m_ext);
  endfunction

  assign ld_m      = c[0];
  assign ld_q      = c[1];
  assign addsub_en = c[2];
  assign sub_sel   = c[3];
  assign shr_en    = c[4];
  assign cnt_inc   = c[5];
  assign out_a     = c[6];
  assign out_q     = c[7];

  // p0: add/sub feeds the arithmetic right shift in the same cycle
  always_comb begin
    a_arith_p0  = a_reg;
    if (addsub_en) begin
      a_arith_p0 = add_sub(a_reg, m_reg, sub_sel);
    end
    a_shift_p0  = {a_arith_p0[WIDTH], a_arith_p0[WIDTH:1]};
    q_shift_p0  = {a_arith_p0[0], q_reg[WIDTH-1:1]};
    qm_shift_p0 = q_reg[0];
  end

  always_comb begin
    a_nxt   = a_reg;
    q_nxt   = q_reg;
    qm_nxt  = qm_reg;
    cnt_nxt = cnt_reg;
    if (ld_q) begin
      a_nxt   = '0;
      q_nxt   = inbus;
      qm_nxt  = 1'b0;
      cnt_nxt = '0;
    end else begin
      if (shr_en) begin
        a_nxt  = a_shift_p0;
        q_nxt  = q_shift_p0;
        qm_nxt = qm_shift_p0;
      end else begin
        a_nxt  = a_arith_p0;
      end
      if (cnt_inc) begin
        cnt_nxt = (cnt_reg == CNT_LAST) ? '0 : cnt_reg + CNT_W'(1);
      end
    end
  end

  // p1: architectural state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_reg   <= '0;
      a_reg   <= '0;
      q_reg   <= '0;
      qm_reg  <= 1'b0;
      cnt_reg <= '0;
    end else begin
      if (ld_m) begin
        m_reg <= inbus;
      end
      a_reg   <= a_nxt;
      q_reg   <= q_nxt;
      qm_reg  <= qm_nxt;
      cnt_reg <= cnt_nxt;
    end
  end

  assign q0    = q_reg[0];
  assign qm    = qm_reg;
  assign count = (cnt_reg == CNT_LAST);

  always_comb begin
    out_sel_p0 = '0;
    if (out_a) begin
      out_sel_p0 = a_reg[WIDTH-1:0];
    end else if (out_q) begin
      out_sel_p0 = q_reg;
    end
  end

`ifdef BOOTH_DP_REG_OUT_EN
  logic [WIDTH-1:0] out_p1;

  // p1: registered result bus
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_p1 <= '0;
    end else begin
      out_p1 <= out_sel_p0;
    end
  end

  assign outbus = out_p1;
`else
  assign outbus = out_sel_p0;
`endif

endmodule

// File: doc/booth_datapath.md
BOOTH_DATAPATH -- requirements
Module: booth_datapath

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 clk  input  1  Rising-edge clock.
REQ-003 rst_n  input  1  Reset: asynchronous, active-low.
REQ-004 c  input  8  Control word from the Booth control unit.
  - c[0] load M; c[1] load Q; c[2] add/sub enable; c[3] subtract select.
  - c[4] arithmetic right shift; c[5] counter increment; c[6] drive A on outbus; c[7] drive Q on outbus.
REQ-005 inbus  input  WIDTH  Operand input, two's complement.
REQ-006 outbus  output  WIDTH  Result output.
REQ-007 q0  output  1  Current Q[0].
REQ-008 qm  output  1  Current Q-1 (Booth extension bit).
REQ-009 count  output  1  Last iteration reached.

Function
REQ-010 State registers SHALL be: M (WIDTH), A (WIDTH+1, sign-extended), Q (WIDTH), Q-1 (1), cnt ($clog2(WIDTH) bits).
REQ-011 On c[0]=1, M SHALL load inbus on the next clock edge.
REQ-012 On c[1]=1, the datapath SHALL update on the next edge as follows:
  - Q loads inbus.
  - A, Q-1 and cnt clear to 0.
  - c[1] overrides c[2], c[4] and c[5] for those registers.
REQ-013 On c[2]=1, A SHALL become A+sext(M) when c[3]=0, or A-sext(M) when c[3]=1, modulo 2^(WIDTH+1); c[3] is ignored when c[2]=0.
REQ-014 On c[4]=1, {A,Q,Q-1} SHALL shift right one bit arithmetically, with A's MSB replicated.
REQ-015 When c[2] and c[4] are both 1 in one cycle, the add/sub result SHALL be shifted in that same cycle, as a combinational chain.
REQ-016 On c[5]=1, cnt SHALL increment by 1, wrapping from WIDTH-1 to 0.
REQ-017 count SHALL be combinational: 1 exactly when cnt==WIDTH-1, giving WIDTH scan/shift iterations per multiply.
REQ-018 q0 SHALL equal Q[0] and qm SHALL equal Q-1, both combinational from registers with zero latency.
REQ-019 outbus source selection SHALL be:
  - c[6]=1: A[WIDTH-1:0].
  - else c[7]=1: Q.
  - else 0.
  - c[6] has priority when both are set.
REQ-020 After a full sequence, {A[WIDTH-1:0],Q} SHALL equal the signed 2*WIDTH-bit product, including for operands of -2^(WIDTH-1).
REQ-021 Registers with no active control bit SHALL hold their value.
REQ-022 c[0] together with c[1] SHALL load M and Q in the same cycle, from the same inbus value.

Reset
REQ-023 While rst_n=0, M, A, Q, Q-1 and cnt SHALL be 0, with no clock required.
REQ-024 During reset, outbus=0, q0=0, qm=0 and count=0.
REQ-025 Reset asserted mid-multiply SHALL abort the operation; no partial state survives.
REQ-026 Release of reset SHALL take effect on the first rising clk edge after rst_n goes high.

Configuration
REQ-027 Macro BOOTH_DP_REG_OUT_EN selects the outbus timing.
  - Defined: outbus is a register loaded per REQ-019 selection each clock, giving 1-cycle latency after c[6]/c[7]; the register resets to 0.
  - Undefined: outbus is combinational per REQ-019 with zero latency.
REQ-028 The macro SHALL NOT affect q0, qm, count or arithmetic results.

Verification
REQ-029 Scenario: WIDTH=8, load M=0x03 and Q=0xFB, run 8 SCAN/SHIFT/CHECK iterations per control-unit sequencing -> A=0xFF, Q=0xF1 (product -15).
REQ-030 Scenario: M=0x80, Q=0x80, full sequence -> A=0x40, Q=0x00 (product 16384); no overflow corruption.
REQ-031 Scenario: after a c[1] load, apply c[5] pulses -> count=0 for cnt 0..6, count=1 after the 7th pulse, count=0 after the 8th (wrap).
REQ-032 Scenario: A=0, Q=0x01, Q-1=0, M=0x05, apply c[2]=c[3]=c[4]=1 in one cycle -> A=0x1FD (low byte 0xFD), Q=0x80, Q-1=1, q0=0, qm=1.
REQ-033 Scenario: rst_n pulsed low mid-multiply, asynchronous to clk -> all registers and outputs read 0 immediately; next c[1] load starts cleanly.
REQ-034 Scenario: c[6] then c[7] on consecutive cycles, using the REQ-029 product.
  - Without BOOTH_DP_REG_OUT_EN: outbus shows 0xFF then 0xF1 in those cycles.
  - With BOOTH_DP_REG_OUT_EN: outbus shows 0xFF then 0xF1 each one cycle later, then 0.
